// File: rtl/btn_input_conditioner.sv
// Multi-channel push-button front end: synchroniser, counter debounce, press/release
// pulses, long-press detection and auto-repeat (enabled by defining BTN_AUTO_REPEAT_EN).
module btn_input_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 20_000_000,
    parameter int BTN_ACTIVE_LOW  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_stable,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long,
    output logic [NUM_BTN-1:0] btn_long_level,
    output logic [NUM_BTN-1:0] btn_repeat
);

    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [DEB_W-1:0]  DEB_MAX    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(LONG_CYCLES - 1);
    localparam logic              ACTIVE_LOW = (BTN_ACTIVE_LOW != 0);
`ifdef BTN_AUTO_REPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
`else
    // Tie-off is written against REPEAT_CYCLES so the parameter stays referenced here.
    assign btn_repeat = {NUM_BTN{REPEAT_CYCLES < 0}};
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic              sync_p0;
        logic              sync_p1;
        logic              level;
        logic [DEB_W-1:0]  deb_cnt_q;
        logic              stable_q;
        logic              deb_flip;
        state_t            state_q;
        state_t            state_d;
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;
        logic              press_q;
        logic              press_d;
        logic              release_q;
        logic              release_d;
        logic              long_q;
        logic              long_d;
        logic              long_lvl_q;
        logic              long_lvl_d;
`ifdef BTN_AUTO_REPEAT_EN
        logic [REP_W-1:0]  rep_q;
        logic [REP_W-1:0]  rep_d;
        logic              repeat_q;
        logic              repeat_d;
`endif

        // Stage p0/p1: two-flop synchroniser; polarity is normalised after p1
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_p0 <= 1'b0;
                sync_p1 <= 1'b0;
            end else begin
                sync_p0 <= btn_in[i];
                sync_p1 <= sync_p0;
            end
        end

        assign level    = sync_p1 ^ ACTIVE_LOW;
        assign deb_flip = (level != stable_q) && (deb_cnt_q == DEB_MAX);

        // Debounce stage: stable level flips after DEBOUNCE_CYCLES consecutive disagreements
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                deb_cnt_q <= '0;
                stable_q  <= 1'b0;
            end else if (level == stable_q) begin
                deb_cnt_q <= '0;
            end else if (deb_flip) begin
                deb_cnt_q <= '0;
                stable_q  <= ~stable_q;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end

        always_comb begin
            state_d    = state_q;
            hold_d     = hold_q;
            press_d    = 1'b0;
            release_d  = 1'b0;
            long_d     = 1'b0;
            long_lvl_d = long_lvl_q;
`ifdef BTN_AUTO_REPEAT_EN
            rep_d      = rep_q;
            repeat_d   = 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (deb_flip && !stable_q) begin
                        state_d = PRESSED;
                        hold_d  = '0;
                        press_d = 1'b1;
                    end
                end
                PRESSED: begin
                    if (deb_flip && stable_q) begin
                        state_d   = IDLE;
                        hold_d    = '0;
                        release_d = 1'b1;
                    end else if (hold_q == HOLD_MAX) begin
                        state_d    = LONG;
                        long_d     = 1'b1;
                        long_lvl_d = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                        rep_d      = '0;
`endif
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                LONG: begin
                    // A release that lands on a due repeat wins; the repeat is dropped.
                    if (deb_flip && stable_q) begin
                        state_d    = IDLE;
                        hold_d     = '0;
                        release_d  = 1'b1;
                        long_lvl_d = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
                        rep_d      = '0;
                    end else if (rep_q == REP_MAX) begin
                        rep_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        rep_d = rep_q + 1'b1;
`endif
                    end
                end
                default: begin
                    state_d    = IDLE;
                    hold_d     = '0;
                    long_lvl_d = 1'b0;
                end
            endcase
        end

        // Output stage: every event output is registered alongside the stable level
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q    <= IDLE;
                hold_q     <= '0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                long_q     <= 1'b0;
                long_lvl_q <= 1'b0;
            end else begin
                state_q    <= state_d;
                hold_q     <= hold_d;
                press_q    <= press_d;
                release_q  <= release_d;
                long_q     <= long_d;
                long_lvl_q <= long_lvl_d;
            end
        end

`ifdef BTN_AUTO_REPEAT_EN
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rep_q    <= '0;
                repeat_q <= 1'b0;
            end else begin
                rep_q    <= rep_d;
                repeat_q <= repeat_d;
            end
        end

        assign btn_repeat[i] = repeat_q;
`endif

        assign btn_stable[i]     = stable_q;
        assign btn_press[i]      = press_q;
        assign btn_release[i]    = release_q;
        assign btn_long[i]       = long_q;
        assign btn_long_level[i] = long_lvl_q;
    end

endmodule

// File: tb/tb_btn_input_conditioner.sv
// Scoreboard bench for btn_input_conditioner: expected pulse vectors are queued by cycle
// when stimulus is applied and compared as the DUT emits pulses.
module tb_btn_input_conditioner;

    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_stable;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long;
    logic [NB-1:0] btn_long_level;
    logic [NB-1:0] btn_repeat;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          cyc;
        logic [11:0] ev;
    } exp_t;

    exp_t exp_q[$];

    btn_input_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .REPEAT_CYCLES  (5),
        .BTN_ACTIVE_LOW (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .btn_stable    (btn_stable),
        .btn_press     (btn_press),
        .btn_release   (btn_release),
        .btn_long      (btn_long),
        .btn_long_level(btn_long_level),
        .btn_repeat    (btn_repeat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // kind: 0 press, 1 release, 2 long, 3 repeat; events in the same cycle are merged
    task automatic push_exp(input int c, input int kind, input logic [NB-1:0] mask);
        logic [11:0] ev;
        ev = 12'(mask) << (3 * kind);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc == c) begin
                exp_q[i].ev = exp_q[i].ev | ev;
                return;
            end
            if (exp_q[i].cyc > c) begin
                exp_q.insert(i, '{c, ev});
                return;
            end
        end
        exp_q.push_back('{c, ev});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [11:0] ev;
        ev = {btn_repeat, btn_long, btn_release, btn_press};
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            check($sformatf("pulses@%0d", cyc), 32'(ev), 32'(exp_q[0].ev));
            void'(exp_q.pop_front());
        end else if (ev != '0) begin
            check($sformatf("unexpected_pulse@%0d", cyc), 32'(ev), 32'd0);
        end
    end

    initial begin
        int t;
        int p;
        int r;
        reset  = 1'b0;
        btn_in = '0;
        #3;
        check("reset_outputs", 32'({btn_stable, btn_press, btn_release, btn_long,
                                    btn_long_level, btn_repeat}), 32'd0);
        tick(3);
        reset = 1'b1;
        tick(2);
        check("idle_outputs", 32'({btn_stable, btn_long_level}), 32'd0);

        // Glitch shorter than the debounce window on channel 0
        btn_in[0] = 1'b1;
        tick(3);
        btn_in[0] = 1'b0;
        tick(10);
        check("glitch_stable0", 32'(btn_stable[0]), 32'd0);

        // Clean press/release on channel 1
        t = cyc;
        btn_in[1] = 1'b1;
        push_exp(t + 6, 0, 3'b010);
        push_exp(t + 18, 1, 3'b010);
        tick(5);
        check("clean_stable1_pre", 32'(btn_stable[1]), 32'd0);
        tick(1);
        check("clean_stable1_on", 32'(btn_stable[1]), 32'd1);
        tick(6);
        btn_in[1] = 1'b0;
        tick(5);
        check("clean_stable1_hold", 32'(btn_stable[1]), 32'd1);
        tick(1);
        check("clean_stable1_off", 32'(btn_stable[1]), 32'd0);
        tick(6);

        // Long hold on channel 2; release timed so a repeat would be due on the release cycle
        t = cyc;
        p = t + 6;
        btn_in[2] = 1'b1;
        push_exp(p, 0, 3'b100);
        push_exp(p + 20, 2, 3'b100);
`ifdef BTN_AUTO_REPEAT_EN
        push_exp(p + 25, 3, 3'b100);
        push_exp(p + 30, 3, 3'b100);
        push_exp(p + 35, 3, 3'b100);
        push_exp(p + 40, 3, 3'b100);
`endif
        push_exp(p + 45, 1, 3'b100);
        tick(25);
        check("long_level2_pre", 32'(btn_long_level[2]), 32'd0);
        tick(1);
        check("long_level2_on", 32'(btn_long_level[2]), 32'd1);
        tick(19);
        btn_in[2] = 1'b0;
        tick(5);
        check("long_level2_hold", 32'({btn_stable[2], btn_long_level[2]}), 32'd3);
        tick(1);
        check("long_level2_drop", 32'({btn_stable[2], btn_long_level[2]}), 32'd0);
        tick(10);

        // Simultaneous press and release on all channels
        t = cyc;
        btn_in = 3'b111;
        push_exp(t + 6, 0, 3'b111);
        push_exp(t + 16, 1, 3'b111);
        tick(6);
        check("simul_stable", 32'(btn_stable), 32'd7);
        tick(4);
        btn_in = 3'b000;
        tick(10);
        check("simul_stable_off", 32'(btn_stable), 32'd0);

        // Bouncy release on channel 1: 2-cycle lows/highs, final fall 8 cycles in
        t = cyc;
        btn_in[1] = 1'b1;
        push_exp(t + 6, 0, 3'b010);
        tick(8);
        for (int k = 0; k < 5; k++) begin
            btn_in[1] = k[0];
            tick(2);
        end
        push_exp(t + 16 + 6, 1, 3'b010);
        check("bounce_stable1_hold", 32'(btn_stable[1]), 32'd1);
        tick(10);
        check("bounce_stable1_off", 32'(btn_stable[1]), 32'd0);

        // Reset while channel 0 is in long hold, then restart with the button still held
        t = cyc;
        btn_in[0] = 1'b1;
        push_exp(t + 6, 0, 3'b001);
        push_exp(t + 26, 2, 3'b001);
        tick(30);
        check("pre_reset_state0", 32'({btn_stable[0], btn_long_level[0]}), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", 32'({btn_stable, btn_press, btn_release, btn_long,
                                          btn_long_level, btn_repeat}), 32'd0);
        @(posedge clk);
        #1;
        r = cyc;
        reset = 1'b1;
        push_exp(r + 6, 0, 3'b001);
        push_exp(r + 26, 2, 3'b001);
        tick(30);
        check("post_reset_long0", 32'({btn_stable[0], btn_long_level[0]}), 32'd3);
        btn_in[0] = 1'b0;
        push_exp(cyc + 6, 1, 3'b001);
        tick(10);
        check("post_reset_off0", 32'({btn_stable[0], btn_long_level[0]}), 32'd0);

        tick(5);
        check("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
